// File: rtl/start_ctrl.sv
// start_ctrl: synchronises and debounces the start button and switches, then holds one start
// request per press until DS_DONE or watchdog abort. Define AUTO_REPEAT_EN for held-button relaunch.
module start_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_IN,
  input  logic [9:0] SW_IN,
  input  logic       DS_IDLE,
  input  logic       DS_DONE,
  output logic       START_OUT,
  output logic [9:0] NUM_OUT,
  output logic       BUSY,
  output logic       ERR,
  output logic [7:0] PRESS_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  logic        btn_meta_q, btn_sync_q;
  logic [9:0]  sw_meta_q, sw_sync_q;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        db_q, db_d, db_prev_q;
  logic        press;
  state_e      state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic        launch, abort;
  logic        rpt_fire;
  logic [9:0]  num_q;
  logic [7:0]  cnt_q;
  logic        err_q;

  if (DEBOUNCE_CYCLES == 20'd0 || TIMEOUT_CYCLES == 16'd0 || REPEAT_CYCLES == 24'd0) begin : g_bad_param
    $error("start_ctrl: cycle-count parameters must be at least 1");
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= BTN_IN;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= SW_IN;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Counter only runs while the synced level disagrees; any agreement restarts the window.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (btn_sync_q != db_q) begin
      if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) db_d = ~db_q;
      else db_cnt_d = db_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      db_cnt_q  <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  assign press = db_q & ~db_prev_q;

`ifdef AUTO_REPEAT_EN
  logic [23:0] rpt_q, rpt_d;

  assign rpt_fire = (rpt_q == REPEAT_CYCLES - 24'd1);

  // Saturates at terminal so a busy downstream only delays the relaunch.
  always_comb begin
    rpt_d = rpt_q;
    if (state_q != S_HOLD || !db_q) rpt_d = '0;
    else if (!rpt_fire) rpt_d = rpt_q + 24'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rpt_q <= '0;
    else          rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    launch  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press && DS_IDLE) begin
          launch  = 1'b1;
          wd_d    = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A completion in the timeout cycle counts as success.
        if (DS_DONE) begin
          state_d = S_HOLD;
        end else if (wd_q == TIMEOUT_CYCLES - 16'd1) begin
          abort   = 1'b1;
          state_d = S_HOLD;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (!db_q) begin
          state_d = S_IDLE;
        end else if (rpt_fire && DS_IDLE) begin
          launch  = 1'b1;
          wd_d    = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      num_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (launch) begin
      num_q <= sw_sync_q;
      cnt_q <= cnt_q + 8'd1;
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    START_OUT = (state_q == S_REQ);
    BUSY      = (state_q != S_IDLE);
  end

  assign NUM_OUT   = num_q;
  assign ERR       = err_q;
  assign PRESS_CNT = cnt_q;

endmodule

// File: tb/tb_start_ctrl.sv
// Bench for start_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_start_ctrl;
  localparam int D = 4;
  localparam int T = 16;
  localparam int R = 32;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BTN_IN = 1'b0;
  logic [9:0] SW_IN = '0;
  logic       DS_IDLE = 1'b0;
  logic       DS_DONE = 1'b0;
  logic       START_OUT, BUSY, ERR;
  logic [9:0] NUM_OUT;
  logic [7:0] PRESS_CNT;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  start_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .TIMEOUT_CYCLES (16'd16),
    .REPEAT_CYCLES  (24'd32)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .BTN_IN   (BTN_IN),
    .SW_IN    (SW_IN),
    .DS_IDLE  (DS_IDLE),
    .DS_DONE  (DS_DONE),
    .START_OUT(START_OUT),
    .NUM_OUT  (NUM_OUT),
    .BUSY     (BUSY),
    .ERR      (ERR),
    .PRESS_CNT(PRESS_CNT)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two-cycle input delay, run-length debounce, request/hold flags.
  bit       m_b1, m_b2, m_db, m_db_prev;
  bit [9:0] m_sw1, m_sw2, m_num;
  bit       m_req, m_hold, m_err;
  bit [7:0] m_cnt;
  int       m_run, m_age, m_rpt;

  initial forever begin
    @(posedge CLK or negedge RESET_N);
    if (!RESET_N) begin
      m_b1 = 0; m_b2 = 0; m_db = 0; m_db_prev = 0;
      m_sw1 = '0; m_sw2 = '0; m_num = '0;
      m_req = 0; m_hold = 0; m_err = 0; m_cnt = '0;
      m_run = 0; m_age = 0; m_rpt = 0;
    end else begin
      bit press_now, go;
      press_now = m_db && !m_db_prev;
      go = 0;
      if (m_req) begin
        if (DS_DONE) begin
          m_req = 0; m_hold = 1; m_rpt = 0;
        end else if (m_age == T - 1) begin
          m_req = 0; m_hold = 1; m_rpt = 0; m_err = 1;
        end else begin
          m_age++;
        end
      end else if (m_hold) begin
        if (!m_db) m_hold = 0;
`ifdef AUTO_REPEAT_EN
        else if (m_rpt == R - 1) go = DS_IDLE;
        else m_rpt++;
`endif
      end else if (press_now && DS_IDLE) begin
        go = 1;
      end
      if (go) begin
        m_req = 1; m_hold = 0; m_age = 0; m_rpt = 0;
        m_num = m_sw2; m_cnt = m_cnt + 8'd1; m_err = 0;
      end
      m_db_prev = m_db;
      if (m_b2 != m_db) begin
        if (m_run == D - 1) begin
          m_db = !m_db; m_run = 0;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      m_b2 = m_b1; m_b1 = BTN_IN;
      m_sw2 = m_sw1; m_sw1 = SW_IN;
    end
  end

  initial forever begin
    @(negedge CLK);
    check("model", {11'b0, START_OUT, BUSY, ERR, PRESS_CNT, NUM_OUT},
          {11'b0, m_req, m_req | m_hold, m_err, m_cnt, m_num});
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  task automatic do_reset;
    RESET_N = 1'b0; BTN_IN = 1'b0; DS_DONE = 1'b0; DS_IDLE = 1'b1;
    step(2);
    RESET_N = 1'b1;
    step(1);
  endtask

  task automatic wait_start(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (START_OUT) begin
        at = cyc;
        break;
      end
      step(1);
    end
    check("start_seen", (at >= 0), 1);
  endtask

  task automatic release_btn;
    BTN_IN = 1'b0;
    step(D + 5);
  endtask

  initial begin
    int c0, at, at2, at3, n;
    int hold_left;

    // Scenario 1: clean press latency and latched operand
    do_reset;
    check("reset_outs", {START_OUT, BUSY, ERR, PRESS_CNT, NUM_OUT}, 0);
    SW_IN = 10'h2A5;
    BTN_IN = 1'b1;
    c0 = cyc;
    wait_start(30, at);
    check("t1_latency", at - c0, D + 3);
    check("t1_num", NUM_OUT, 10'h2A5);
    check("t1_cnt", PRESS_CNT, 1);
    check("t1_busy", BUSY, 1);

    // Scenario 3: operand frozen, DS_DONE ends request, hold until release
    SW_IN = 10'h001;
    step(5);
    check("t3_still_req", START_OUT, 1);
    check("t3_num_frozen", NUM_OUT, 10'h2A5);
    DS_DONE = 1'b1;
    step(1);
    DS_DONE = 1'b0;
    check("t3_start_fall", START_OUT, 0);
    check("t3_num_after", NUM_OUT, 10'h2A5);
    step(10);
    check("t3_hold_busy", BUSY, 1);
    release_btn;
    check("t3_released", BUSY, 0);

    // Scenario 2: bouncing button never launches
    do_reset;
    for (int i = 0; i < 10; i++) begin
      BTN_IN = ~BTN_IN;
      step(2);
    end
    BTN_IN = 1'b0;
    step(D + 6);
    check("t2_cnt", PRESS_CNT, 0);
    check("t2_busy", BUSY, 0);

    // Scenario 4: watchdog abort then recovery
    do_reset;
    SW_IN = 10'($urandom);
    BTN_IN = 1'b1;
    wait_start(30, at);
    n = 0;
    while (START_OUT && n < 40) begin
      n++;
      step(1);
    end
    check("t4_req_len", n, T);
    check("t4_err", ERR, 1);
    release_btn;
    SW_IN = 10'h3C3;
    BTN_IN = 1'b1;
    wait_start(30, at);
    check("t4_err_clr", ERR, 0);
    check("t4_cnt", PRESS_CNT, 2);
    check("t4_num", NUM_OUT, 10'h3C3);
    release_btn;

    // Scenario 5: busy downstream, done/timeout tie, reset during request
    do_reset;
    DS_IDLE = 1'b0;
    BTN_IN = 1'b1;
    step(D + 10);
    check("t5_no_launch", {BUSY, PRESS_CNT}, 0);
    DS_IDLE = 1'b1;
    step(D + 10);
    check("t5_no_retrigger", {BUSY, PRESS_CNT}, 0);
    release_btn;
    BTN_IN = 1'b1;
    wait_start(30, at);
    step(T - 1);
    DS_DONE = 1'b1;
    step(1);
    DS_DONE = 1'b0;
    check("t5_tie_start", START_OUT, 0);
    check("t5_tie_err", ERR, 0);
    release_btn;
    BTN_IN = 1'b1;
    wait_start(30, at);
    step(2);
    RESET_N = 1'b0;
    BTN_IN = 1'b0;
    #1;
    check("t5_async_reset", {START_OUT, BUSY, PRESS_CNT}, 0);
    step(2);
    RESET_N = 1'b1;
    step(20);
    check("t5_no_replay", {BUSY, PRESS_CNT}, 0);

    // Scenario 6: held button with prompt completions
    do_reset;
    BTN_IN = 1'b1;
    wait_start(30, at);
    step(2);
    DS_DONE = 1'b1;
    step(1);
    DS_DONE = 1'b0;
`ifdef AUTO_REPEAT_EN
    wait_start(80, at2);
    check("t6_period1", at2 - at, R + 3);
    step(2);
    DS_DONE = 1'b1;
    step(1);
    DS_DONE = 1'b0;
    wait_start(80, at3);
    check("t6_period2", at3 - at2, R + 3);
    check("t6_cnt", PRESS_CNT, 3);
`else
    at2 = at;
    at3 = at;
    step(100);
    check("t6_single", PRESS_CNT, 1);
    check("t6_hold", {START_OUT, BUSY}, 2'b01);
`endif
    release_btn;

    // Randomized traffic checked every cycle by the model
    do_reset;
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        BTN_IN = ~BTN_IN;
        hold_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
      end
      hold_left--;
      if ($urandom_range(0, 3) == 0) SW_IN = 10'($urandom);
      DS_IDLE = ($urandom_range(0, 7) != 0);
      DS_DONE = START_OUT ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      RESET_N = ($urandom_range(0, 599) != 0);
      step(1);
    end
    RESET_N = 1'b1;
    DS_DONE = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/start_ctrl.md
Name: start_ctrl

Overview:
Front-end stage directly upstream of the bitcount IP wrapper. It synchronises and debounces the start push-button and the 10 NUM slide switches. It then issues a level start request with a latched operand and holds it until the downstream stage signals completion. It also provides press counting, a stuck-request watchdog and press-release re-arming, so the downstream stage sees exactly one clean request per physical press.

Parameters:
DEBOUNCE_CYCLES, 20'd1000000, consecutive stable cycles required before the debounced button state changes (>=1)
TIMEOUT_CYCLES, 16'd1000, maximum cycles START_OUT stays high without DS_DONE before abort (>=1)
REPEAT_CYCLES, 24'd5000000, hold interval between auto-repeat launches (used only with AUTO_REPEAT_EN)

Ports:
CLK  in  1  system clock, single clock domain
RESET_N  in  1  asynchronous, active-low reset
BTN_IN  in  1  raw push-button, asynchronous, bouncing
SW_IN  in  10  raw slide switches, asynchronous
DS_IDLE  in  1  downstream idle (ap_idle)
DS_DONE  in  1  downstream completion pulse (ap_done)
START_OUT  out  1  start request to downstream (drives ap_start)
NUM_OUT  out  10  operand, stable while START_OUT high
BUSY  out  1  high in REQ or HOLD
ERR  out  1  sticky watchdog-abort flag
PRESS_CNT  out  8  count of accepted launches

Behaviour:
- Reset: RESET_N low asynchronously clears every flop. All outputs are 0, the FSM is in IDLE and the debounced state is 0. Reset mid-request drops START_OUT immediately; no request is replayed after release.
- Sync: 2-FF synchroniser on BTN_IN and on each SW_IN bit. The synchronised switch word is sampled only at launch.
- Debounce:
  - Counter increments each cycle the synced button differs from the debounced state; it clears to 0 on any match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced state toggles and the counter clears.
  - press = debounced rising edge, a 1-cycle combinational strobe.
- Latency: BTN_IN first sampled high at edge 1, with no bounce. START_OUT rises at edge DEBOUNCE_CYCLES+3.
- FSM:
  - IDLE:
    - press & DS_IDLE -> NUM_OUT <= synced SW_IN, START_OUT <= 1, PRESS_CNT++, ERR <= 0, watchdog <= 0; go REQ.
    - press & !DS_IDLE -> press dropped; stay IDLE (must release and re-press).
    - DS_DONE is ignored in IDLE.
  - REQ:
    - START_OUT held high and NUM_OUT frozen; watchdog increments each cycle.
    - DS_DONE -> START_OUT <= 0; go HOLD.
    - Watchdog reaches TIMEOUT_CYCLES-1 without DS_DONE -> START_OUT <= 0, ERR <= 1; go HOLD.
    - DS_DONE and timeout in the same cycle: DS_DONE wins, ERR unchanged.
  - HOLD: debounced button = 0 -> IDLE. A held button never retriggers.
- PRESS_CNT: 8-bit, wraps 255 -> 0. NUM_OUT holds its last launched value between requests.
- SW_IN changes during REQ or HOLD do not affect NUM_OUT.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - In HOLD with the button still debounced high, a repeat counter runs.
  - On reaching REPEAT_CYCLES-1 with DS_IDLE=1, the block relaunches exactly as IDLE does: fresh SW sample, PRESS_CNT++, go REQ.
  - If DS_IDLE=0 at that point, the counter holds at terminal until DS_IDLE=1.
  - The repeat counter clears on entry to HOLD and on release.
- Undefined: no repeat logic; release is required. The REPEAT_CYCLES parameter is present but unused.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16, REPEAT_CYCLES=32):
1. Reset, SW_IN=10'h2A5, BTN_IN high clean at edge 1, DS_IDLE=1 -> START_OUT=1 at edge 7, NUM_OUT=10'h2A5, PRESS_CNT=1, BUSY=1.
2. BTN_IN toggling every 2 cycles for 20 cycles, then low -> START_OUT never rises, PRESS_CNT=0.
3. Launch, change SW_IN to 10'h001, DS_DONE pulse 5 cycles later -> NUM_OUT stays 10'h2A5 until DS_DONE; START_OUT falls the next edge; HOLD until release.
4. Launch with no DS_DONE -> START_OUT falls after 16 REQ cycles, ERR=1. Next accepted press -> ERR=0, PRESS_CNT=2.
5. Press with DS_IDLE=0 -> no launch. DS_DONE and timeout in the same cycle -> ERR stays 0. RESET_N low during REQ -> START_OUT=0 immediately.
6. AUTO_REPEAT_EN defined, button held, DS_DONE 3 cycles after each launch -> relaunch every 32 HOLD cycles, PRESS_CNT increments. Undefined -> single launch only.
